// File: rtl/sa_sched_pkg.sv
// Shared definitions for the systolic-array sequencer: array geometry,
// data/index widths, fixed-point format and the sequencer state encoding.
package sa_sched_pkg;

  localparam int unsigned N    = 4;               // lanes per array edge
  localparam int unsigned DW   = 16;              // data width per lane
  localparam int unsigned KW   = 8;               // accumulation-depth width
  localparam int unsigned RW   = 2;               // result-row index width
  localparam int unsigned FRAC = 8;               // fraction bits of the PE data
  localparam int unsigned FW   = $clog2(2 * N);   // flush counter width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // States in which a job is considered in progress
  function automatic logic is_busy(input state_t s);
    return (s == ST_FEED) || (s == ST_FLUSH) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/sa_sched_skew_line.sv
// Per-lane delay chain: lane i is delayed i+1 cycles. When vld_i is low
// the lane inputs are replaced by zero so idle cycles inject zero bubbles.
module skew_line
  import sa_sched_pkg::*;
#(
  parameter int unsigned LANES = N,
  parameter int unsigned WIDTH = DW
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   vld_i,
  input  logic [LANES*WIDTH-1:0] vec_i,
  output logic [LANES*WIDTH-1:0] vec_o
);

  logic [LANES*WIDTH-1:0] w_in;

  assign w_in = vld_i ? vec_i : '0;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [WIDTH-1:0] r_sh [0:gi];

    // Shift register of depth gi+1 for this lane
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int d = 0; d <= gi; d++) r_sh[d] <= '0;
      end else begin
        r_sh[0] <= w_in[gi*WIDTH +: WIDTH];
        for (int d = 1; d <= gi; d++) r_sh[d] <= r_sh[d-1];
      end
    end

    assign vec_o[gi*WIDTH +: WIDTH] = r_sh[gi];
  end

endmodule

// File: rtl/sa_sched.sv
// Systolic-array job sequencer: feeds K operand vectors through skew lines,
// issues the accumulator clear, waits out the pipeline and drains N result
// rows over valid/ready. Optional macro SA_SCHED_PERF_EN enables the
// per-job cycle counter on perf_cycles_o.
module sa_sched
  import sa_sched_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [KW-1:0]     k_len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [KW-1:0]     rd_k_o,
  input  logic [N*DW-1:0]   a_vec_i,
  input  logic [N*DW-1:0]   b_vec_i,
  output logic [N*DW-1:0]   srca_o,
  output logic [N*DW-1:0]   srcb_o,
  output logic              clr_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [RW-1:0]     res_row_o,
  output logic [31:0]       perf_cycles_o
);

  state_t          r_state, w_state_nxt;
  logic [KW-1:0]   r_klen, w_klen_nxt;
  logic [KW-1:0]   r_k, w_k_nxt;
  logic [FW-1:0]   r_fcnt, w_fcnt_nxt;
  logic [RW-1:0]   r_row, w_row_nxt;
  logic            r_busy, r_done, r_rd_en, r_clr, r_res_valid;
  logic            w_clr_nxt;
  logic            w_hs;

  assign w_hs = r_res_valid & res_ready_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and counter update logic
  always_comb begin
    w_state_nxt = r_state;
    w_klen_nxt  = r_klen;
    w_k_nxt     = '0;
    w_fcnt_nxt  = '0;
    w_row_nxt   = '0;
    w_clr_nxt   = (r_state == ST_FEED) && (r_k == '0);
    unique case (r_state)
      ST_IDLE: begin
        if (start_i && (k_len_i != '0)) begin
          w_klen_nxt  = k_len_i;
          w_state_nxt = ST_FEED;
        end
      end
      ST_FEED: begin
        if (r_k == r_klen - KW'(1)) w_state_nxt = ST_FLUSH;
        else                        w_k_nxt     = r_k + KW'(1);
      end
      ST_FLUSH: begin
        if (r_fcnt == FW'(2 * N - 1)) w_state_nxt = ST_DRAIN;
        else                          w_fcnt_nxt  = r_fcnt + FW'(1);
      end
      ST_DRAIN: begin
        w_row_nxt = r_row;
        if (w_hs) begin
          if (r_row == RW'(N - 1)) begin
            w_row_nxt   = '0;
            w_state_nxt = ST_DONE;
          end else begin
            w_row_nxt = r_row + RW'(1);
          end
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Counters and registered outputs, decoded from the upcoming state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_klen      <= '0;
      r_k         <= '0;
      r_fcnt      <= '0;
      r_row       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_clr       <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_klen      <= w_klen_nxt;
      r_k         <= w_k_nxt;
      r_fcnt      <= w_fcnt_nxt;
      r_row       <= w_row_nxt;
      r_busy      <= is_busy(w_state_nxt);
      r_done      <= (w_state_nxt == ST_DONE);
      r_rd_en     <= (w_state_nxt == ST_FEED);
      r_clr       <= w_clr_nxt;
      r_res_valid <= (w_state_nxt == ST_DRAIN);
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign rd_en_o     = r_rd_en;
  assign rd_k_o      = r_k;
  assign clr_o       = r_clr;
  assign res_valid_o = r_res_valid;
  assign res_row_o   = r_row;

  skew_line #(.LANES(N), .WIDTH(DW)) u_skew_a (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .vld_i (r_rd_en),
    .vec_i (a_vec_i),
    .vec_o (srca_o)
  );

  skew_line #(.LANES(N), .WIDTH(DW)) u_skew_b (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .vld_i (r_rd_en),
    .vec_i (b_vec_i),
    .vec_o (srcb_o)
  );

`ifdef SA_SCHED_PERF_EN
  logic [31:0] r_perf;

  // Job cycle counter: cleared on acceptance, counts every non-idle cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                           r_perf <= '0;
    else if (r_state == ST_IDLE && w_state_nxt == ST_FEED) r_perf <= '0;
    else if (r_state != ST_IDLE)                         r_perf <= r_perf + 32'd1;
  end

  assign perf_cycles_o = r_perf;
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_sa_sched.sv
// Self-checking bench for sa_sched: randomized jobs compared cycle by cycle
// against a timeline model derived from the job length K and the ready
// pattern, plus directed zero-K, stall, spurious-start and reset cases.
module tb_sa_sched;
  import sa_sched_pkg::*;

  logic            clk, rst, start, res_ready;
  logic [KW-1:0]   k_len;
  logic            busy, done, rd_en, clr, res_valid;
  logic [KW-1:0]   rd_k;
  logic [RW-1:0]   res_row;
  logic [N*DW-1:0] a_vec, b_vec, srca, srcb, junk;
  logic [31:0]     perf;

  logic [N*DW-1:0] mem_a [256];
  logic [N*DW-1:0] mem_b [256];

  int n_tests = 0;
  int n_fail  = 0;

  sa_sched dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .k_len_i       (k_len),
    .busy_o        (busy),
    .done_o        (done),
    .rd_en_o       (rd_en),
    .rd_k_o        (rd_k),
    .a_vec_i       (a_vec),
    .b_vec_i       (b_vec),
    .srca_o        (srca),
    .srcb_o        (srcb),
    .clr_o         (clr),
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .res_row_o     (res_row),
    .perf_cycles_o (perf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand buffer: valid data while reading, garbage otherwise
  assign a_vec = rd_en ? mem_a[rd_k] : junk;
  assign b_vec = rd_en ? mem_b[rd_k] : ~junk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected edge vector: element k of lane i appears d = k+i+2 cycles after acceptance
  function automatic logic [N*DW-1:0] exp_skew(input bit is_a, input int d, input int k_len_v);
    logic [N*DW-1:0] v;
    logic [N*DW-1:0] word;
    int kk;
    v = '0;
    for (int i = 0; i < N; i++) begin
      kk = d - 2 - i;
      if (kk >= 0 && kk < k_len_v) begin
        word = is_a ? mem_a[kk] : mem_b[kk];
        v[i*DW +: DW] = word[i*DW +: DW];
      end
    end
    return v;
  endfunction

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"},  64'(busy), 64'(0));
    chk({pfx, "_done"},  64'(done), 64'(0));
    chk({pfx, "_rd_en"}, 64'(rd_en), 64'(0));
    chk({pfx, "_rd_k"},  64'(rd_k), 64'(0));
    chk({pfx, "_clr"},   64'(clr), 64'(0));
    chk({pfx, "_valid"}, 64'(res_valid), 64'(0));
    chk({pfx, "_row"},   64'(res_row), 64'(0));
    chk({pfx, "_srca"},  64'(srca), 64'(0));
    chk({pfx, "_srcb"},  64'(srcb), 64'(0));
  endtask

  task automatic fill_mem(input bit directed);
    for (int k = 0; k < 256; k++) begin
      if (directed) begin
        mem_a[k] = {N{16'h0100}};
        mem_b[k] = {N{16'h0200}};
      end else begin
        mem_a[k] = {$urandom(), $urandom()};
        mem_b[k] = {$urandom(), $urandom()};
      end
    end
  endtask

  // One job from acceptance to the idle cycle after done
  task automatic run_job(input int kl, input int stall_row, input int stall_len, input bit noise);
    int row, stall_left, done_d, drain_start, exp_perf;
    bit feed, vld, dn;
    row = 0; stall_left = stall_len; done_d = -1; drain_start = kl + 2*N + 1;
    @(negedge clk);
    start = 1'b1; k_len = KW'(kl); res_ready = 1'b1;
    for (int d = 1; d <= kl + 3*N + 300; d++) begin
      @(negedge clk);
      feed = (d <= kl);
      vld  = (d >= drain_start) && (row < N);
      dn   = (row == N);
      chk("busy",  64'(busy),      64'(!dn));
      chk("done",  64'(done),      64'(dn));
      chk("rd_en", 64'(rd_en),     64'(feed));
      chk("rd_k",  64'(rd_k),      feed ? 64'(d - 1) : 64'(0));
      chk("clr",   64'(clr),       64'(d == 2));
      chk("valid", 64'(res_valid), 64'(vld));
      chk("row",   64'(res_row),   vld ? 64'(row) : 64'(0));
      chk("srca",  64'(srca),      64'(exp_skew(1'b1, d, kl)));
      chk("srcb",  64'(srcb),      64'(exp_skew(1'b0, d, kl)));
      if (dn) begin
        done_d = d;
        start  = 1'b0;
        break;
      end
      if (vld && row == stall_row && stall_left > 0) begin
        res_ready = 1'b0;
        stall_left--;
      end else begin
        res_ready = noise ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (vld && res_ready) row++;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      k_len = KW'($urandom_range(1, 9));
      junk  = {$urandom(), $urandom()};
    end
    if (done_d < 0) begin
      chk("timeout", 64'(0), 64'(1));
      start = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    chk_zero("idle");
`ifdef SA_SCHED_PERF_EN
    exp_perf = done_d;
`else
    exp_perf = 0;
`endif
    chk("perf", 64'(perf), 64'(exp_perf));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; res_ready = 1'b1; junk = '0;
    fill_mem(1'b1);
    repeat (2) @(negedge clk);
    chk_zero("rst");
    chk("rst_perf", 64'(perf), 64'(0));
    rst = 1'b0;

    // Directed K=3 timeline with ready tied high
    run_job(3, -1, 0, 1'b0);

    // Writeback stall on row 2
    fill_mem(1'b0);
    run_job(3, 2, 5, 1'b0);

    // Zero-length start is ignored
    @(negedge clk);
    start = 1'b1; k_len = '0;
    repeat (6) begin
      @(negedge clk);
      chk("k0_rd_en", 64'(rd_en), 64'(0));
      chk("k0_busy",  64'(busy),  64'(0));
    end
    start = 1'b0;

    // Spurious starts and random ready during the job
    run_job(4, -1, 0, 1'b1);

    // Reset in the middle of FEED
    @(negedge clk);
    start = 1'b1; k_len = KW'(10);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle_busy",  64'(busy),  64'(0));
    chk("midrst_idle_rd_en", 64'(rd_en), 64'(0));
    fill_mem(1'b0);
    run_job(5, -1, 0, 1'b0);

    // Randomized jobs, including the maximum depth
    for (int j = 0; j < 6; j++) begin
      fill_mem(1'b0);
      run_job($urandom_range(1, 20), $urandom_range(0, N - 1), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    run_job(255, 1, 3, 1'b1);
    run_job(1, -1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sa_sched.md
# sa_sched

Sequencer for an N×N systolic array of MAC processing elements (16-bit signed fixed-point, 8 fraction bits, 2-cycle src-to-psum latency, one-cycle clear propagation per hop). One job computes C = A·B with accumulation depth K. The block reads A/B vectors from the operand buffers, skews them onto the array edges with zero fill, and issues the single accumulator-clear pulse. It waits out the pipeline and then hands the result rows to the writeback path over a valid/ready handshake.

## Interface
- N, 4, array dimension (lanes per edge)
- DW, 16, data width per lane
- KW, 8, width of accumulation-depth and k-index fields
- RW, 2, width of res_row_o (≥ clog2(N))
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  job request, sampled only in IDLE
- k_len_i  in  KW  accumulation depth K, sampled with start_i
- busy_o  out  1  high in FEED, FLUSH, DRAIN
- done_o  out  1  one-cycle pulse at job end
- rd_en_o  out  1  operand buffer read strobe
- rd_k_o  out  KW  k index of current read
- a_vec_i  in  N*DW  A column k, lane i at [i*DW+:DW], valid same cycle as rd_en_o
- b_vec_i  in  N*DW  B row k, same layout
- srca_o  out  N*DW  skewed A to array west edge
- srcb_o  out  N*DW  skewed B to array north edge
- clr_o  out  1  accumulator clear into PE(0,0)
- res_valid_o  out  1  result row r stable on array psum outputs
- res_ready_i  in  1  writeback accepts row
- res_row_o  out  RW  row index r
- perf_cycles_o  out  32  job cycle count (see Configuration)

## Operation
- States: IDLE, FEED, FLUSH, DRAIN, DONE. Reset → IDLE.
- IDLE: when start_i=1 and k_len_i≠0, latch K and go to FEED. start_i with k_len_i=0 is ignored.
- FEED: runs K cycles with rd_en_o=1 and rd_k_o=0..K-1 incrementing, then goes to FLUSH.
- FLUSH: a 2N-cycle counter. rd_en_o=0. Goes to DRAIN.
- DRAIN: res_valid_o=1 with res_row_o=r, starting at r=0. r increments on res_valid_o&&res_ready_i. The handshake on r=N-1 goes to DONE.
- DONE: done_o=1 for one cycle, then IDLE. start_i is ignored in every state except IDLE.
- Skew: lane i of a_vec_i/b_vec_i is delayed i+1 cycles to srca_o/srcb_o lane i. A lane's input is forced to zero when rd_en_o=0, so zero bubbles keep finished accumulators constant.
- clr_o=1 exactly one cycle, aligned with the k=0 element on lane 0, i.e. the cycle after the first FEED cycle.
- Arithmetic: counters only. K is unsigned; K=2^KW-1 is legal.
- Reset mid-job: immediate return to IDLE. All outputs go to 0 and the skew registers clear. No done_o is produced.
- res_ready_i held low stalls DRAIN indefinitely, and the array psums stay valid (inputs are zero).

## Timing
- Reset values: busy_o, done_o, rd_en_o, clr_o, res_valid_o = 0; rd_k_o, res_row_o, srca_o, srcb_o, perf_cycles_o = 0.
- c0 is the first FEED cycle, which is the cycle after start_i is accepted.
- The element for k reaches PE(i,j) at c0+1+k+i+j.
- The psum of PE(i,j) is final from c0+K+i+j+2. The whole array is final at c0+K+2N, which is the first DRAIN cycle.
- With res_ready_i tied to 1: done_o at c0+K+3N, busy_o low from that cycle. Total from start_i to done_o is K+3N+1 cycles.

## Configuration
- SA_SCHED_PERF_EN
  - Defined: perf_cycles_o counts cycles from the start_i acceptance through DONE inclusive. It holds its value in IDLE and clears on the next accepted start.
  - Undefined: counter logic is omitted and perf_cycles_o is constant 0.

## Structure
- Shared package: state encoding constants, the default N/DW/KW, and the fraction-bit count (8).
- Sub-module skew_line: the per-lane delay chain of depth i+1 with a zero-insert input. The sequencer instantiates one for A and one for B.

## Test plan
- N=4, K=3, start at cycle s → rd_en_o high s+1..s+3 with rd_k_o 0,1,2. clr_o high only at s+2. res_valid_o first at s+12. done_o at s+16.
- A all 0x0100 (1.0), B all 0x0200 (2.0), K=3, array attached → all 16 psums read 0x0600 in DRAIN.
- k_len_i=0 with start_i → stays IDLE, rd_en_o never asserts. start_i asserted during FLUSH → ignored, no second job.
- res_ready_i low for 5 cycles on row 2 → res_row_o holds 2 and res_valid_o stays 1. Rows accepted in order 0..3, then done_o.
- rst_i asserted mid-FEED → next cycle all outputs 0 and state IDLE. A fresh job then completes with correct results.
- With SA_SCHED_PERF_EN, N=4, K=3, ready tied 1 → perf_cycles_o=16. Without the macro → 0.
